// File: rtl/bayer_pkg.sv
// Shared definitions for the RGB-to-Bayer raw converter: FSM state
// encoding, GRBG colour phases and the 8-to-10-bit sample expansion.
package bayer_pkg;

    localparam int PIX_W   = 8;
    localparam int RAW_W   = 10;
    localparam int CNT_W   = 11;
    localparam int BLANK_W = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        V_FRONT = 3'd1,
        ACTIVE  = 3'd2,
        H_GAP   = 3'd3,
        V_TAIL  = 3'd4
    } bayerState_t;

    // Phase index is {row[0], col[0]}; GRBG puts green on the diagonal.
    typedef enum logic [1:0] {
        PH_GR_G = 2'b00,
        PH_GR_R = 2'b01,
        PH_BG_B = 2'b10,
        PH_BG_G = 2'b11
    } bayerPhase_t;

    // Replicate the top bits so full scale maps to full scale (0xFF -> 0x3FF).
    function automatic logic [RAW_W-1:0] expand10(input logic [PIX_W-1:0] c);
        return {c, c[PIX_W-1:PIX_W-2]};
    endfunction

endpackage

// File: rtl/bayer_timing_gen.sv
// Frame/line timing for the Bayer converter: sequences the front porch,
// active lines, horizontal gaps and vertical tail, and owns the X/Y counters.
module bayer_timing_gen
    import bayer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 4
) (
    input  logic             CCD_PIXCLK,
    input  logic             RST,
    input  logic             startReq,
    output logic             lineActive,
    output logic             frameActive,
    output logic [CNT_W-1:0] xCnt,
    output logic [CNT_W-1:0] yCnt
);

    localparam logic [BLANK_W-1:0] GAP_LAST  = BLANK_W'(H_BLANK - 1);
    localparam logic [BLANK_W-1:0] TAIL_LAST = BLANK_W'(V_BLANK * (H_ACTIVE + H_BLANK) - 1);
    localparam logic [CNT_W-1:0]   X_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]   Y_LAST    = CNT_W'(V_ACTIVE - 1);

    bayerState_t          state;
    logic [BLANK_W-1:0]   blankCnt;

    // Frame FSM; lineActive/frameActive are updated on each transition so they
    // always match the state register without a decode stage.
    always_ff @(posedge CCD_PIXCLK) begin
        if (RST) begin
            state       <= IDLE;
            blankCnt    <= '0;
            xCnt        <= '0;
            yCnt        <= '0;
            lineActive  <= 1'b0;
            frameActive <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The SOF pixel only opens the frame; it is not consumed.
                    if (startReq) begin
                        state       <= V_FRONT;
                        blankCnt    <= '0;
                        frameActive <= 1'b1;
                    end
                end
                V_FRONT: begin
                    if (blankCnt == GAP_LAST) begin
                        state      <= ACTIVE;
                        xCnt       <= '0;
                        yCnt       <= '0;
                        lineActive <= 1'b1;
                    end else begin
                        blankCnt <= blankCnt + BLANK_W'(1);
                    end
                end
                ACTIVE: begin
                    // Line length is fixed; missing pixels do not stretch it.
                    if (xCnt == X_LAST) begin
                        state      <= H_GAP;
                        blankCnt   <= '0;
                        lineActive <= 1'b0;
                    end else begin
                        xCnt <= xCnt + CNT_W'(1);
                    end
                end
                H_GAP: begin
                    if (blankCnt == GAP_LAST) begin
                        blankCnt <= '0;
                        if (yCnt == Y_LAST) begin
                            state       <= V_TAIL;
                            frameActive <= 1'b0;
                        end else begin
                            state      <= ACTIVE;
                            xCnt       <= '0;
                            yCnt       <= yCnt + CNT_W'(1);
                            lineActive <= 1'b1;
                        end
                    end else begin
                        blankCnt <= blankCnt + BLANK_W'(1);
                    end
                end
                V_TAIL: begin
                    if (blankCnt == TAIL_LAST) begin
                        state    <= IDLE;
                        blankCnt <= '0;
                        xCnt     <= '0;
                        yCnt     <= '0;
                    end else begin
                        blankCnt <= blankCnt + BLANK_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    lineActive  <= 1'b0;
                    frameActive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rgb2raw_bayer.sv
// RGB to GRBG Bayer raw converter: picks one colour per pixel position,
// expands it to 10 bits and presents a CCD-style LVAL/FVAL stream.
module rgb2raw_bayer
    import bayer_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 4
) (
    input  logic             CCD_PIXCLK,
    input  logic             RST,
    input  logic [PIX_W-1:0] iRed,
    input  logic [PIX_W-1:0] iGreen,
    input  logic [PIX_W-1:0] iBlue,
    input  logic             iVALID,
    input  logic             iSOF,
    output logic             oREADY,
    output logic [RAW_W-1:0] oCCD_DATA,
    output logic             oCCD_LVAL,
    output logic             oCCD_FVAL,
    output logic [CNT_W-1:0] oX_Cont,
    output logic [CNT_W-1:0] oY_Cont,
    output logic             oUNDERRUN,
    output logic             oFRAME_ERR
);

    logic             lineActive;
    logic             frameActive;
    logic [CNT_W-1:0] xCnt;
    logic [CNT_W-1:0] yCnt;
    logic             accept;
    logic [RAW_W-1:0] pixRaw;

    bayer_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_BLANK  (V_BLANK)
    ) uTiming (
        .CCD_PIXCLK  (CCD_PIXCLK),
        .RST         (RST),
        .startReq    (iVALID && iSOF),
        .lineActive  (lineActive),
        .frameActive (frameActive),
        .xCnt        (xCnt),
        .yCnt        (yCnt)
    );

    assign oREADY = lineActive;
    assign accept = iVALID && lineActive;

    // GRBG colour pick for the position the timing generator is on now.
    always_comb begin
        pixRaw = '0;
        case (bayerPhase_t'({yCnt[0], xCnt[0]}))
            PH_GR_G, PH_BG_G: pixRaw = expand10(iGreen);
            PH_GR_R:          pixRaw = expand10(iRed);
            PH_BG_B:          pixRaw = expand10(iBlue);
            default:          pixRaw = '0;
        endcase
    end

    // Output stage: everything registered together so data, syncs and
    // coordinates stay aligned one cycle behind the accepting edge.
    always_ff @(posedge CCD_PIXCLK) begin
        if (RST) begin
            oCCD_DATA  <= '0;
            oCCD_LVAL  <= 1'b0;
            oCCD_FVAL  <= 1'b0;
            oX_Cont    <= '0;
            oY_Cont    <= '0;
            oUNDERRUN  <= 1'b0;
            oFRAME_ERR <= 1'b0;
        end else begin
            oCCD_DATA  <= accept ? pixRaw : '0;
            oCCD_LVAL  <= lineActive;
            oCCD_FVAL  <= frameActive;
            oX_Cont    <= xCnt;
            oY_Cont    <= yCnt;
            oUNDERRUN  <= lineActive && !iVALID;
            // A stray SOF is taken as a plain pixel; only flag it.
            oFRAME_ERR <= accept && iSOF && ((xCnt != '0) || (yCnt != '0));
        end
    end

endmodule

// File: tb/tb_rgb2raw_bayer.sv
// Directed bench for rgb2raw_bayer on a 4x2 frame with short blanking.
module tb_rgb2raw_bayer;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int HB   = 2;
    localparam int VB   = 1;
    localparam int NPIX = H * V;

    logic        CCD_PIXCLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  iRed = 8'h10;
    logic [7:0]  iGreen = 8'h20;
    logic [7:0]  iBlue = 8'hFF;
    logic        iVALID = 1'b0;
    logic        iSOF = 1'b0;
    logic        oREADY;
    logic [9:0]  oCCD_DATA;
    logic        oCCD_LVAL;
    logic        oCCD_FVAL;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic        oUNDERRUN;
    logic        oFRAME_ERR;

    int checks = 0;
    int errors = 0;

    // Per-frame log of LVAL-high samples
    logic [9:0]  logData [NPIX];
    logic [10:0] logX [NPIX];
    logic [10:0] logY [NPIX];
    logic        logUnd [NPIX];
    logic        logErr [NPIX];
    int          nLog;
    int          lineLen [4];
    int          nLines;
    int          undTotal;
    int          errTotal;

    // Expected row data for R=0x10, G=0x20, B=0xFF in GRBG order
    logic [9:0]  expData [NPIX] = '{10'h080, 10'h040, 10'h080, 10'h040,
                                    10'h3FF, 10'h080, 10'h3FF, 10'h080};

    rgb2raw_bayer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .V_BLANK  (VB)
    ) dut (
        .CCD_PIXCLK (CCD_PIXCLK),
        .RST        (RST),
        .iRed       (iRed),
        .iGreen     (iGreen),
        .iBlue      (iBlue),
        .iVALID     (iVALID),
        .iSOF       (iSOF),
        .oREADY     (oREADY),
        .oCCD_DATA  (oCCD_DATA),
        .oCCD_LVAL  (oCCD_LVAL),
        .oCCD_FVAL  (oCCD_FVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oUNDERRUN  (oUNDERRUN),
        .oFRAME_ERR (oFRAME_ERR)
    );

    always #5 CCD_PIXCLK = ~CCD_PIXCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        check({pfx, "_ready"}, oREADY, 0);
        check({pfx, "_data"},  oCCD_DATA, 0);
        check({pfx, "_lval"},  oCCD_LVAL, 0);
        check({pfx, "_fval"},  oCCD_FVAL, 0);
        check({pfx, "_x"},     oX_Cont, 0);
        check({pfx, "_y"},     oY_Cont, 0);
        check({pfx, "_und"},   oUNDERRUN, 0);
        check({pfx, "_ferr"},  oFRAME_ERR, 0);
    endtask

    task automatic pulseReset(input string pfx);
        iSOF = 1'b0;
        RST  = 1'b1;
        @(negedge CCD_PIXCLK);
        checkAllZero(pfx);
        RST = 1'b0;
    endtask

    // Start a frame with an SOF pulse, stream continuous pixels and log
    // outputs until FVAL falls. dropIdx/sofIdx/rstIdx select the accepted
    // pixel index (row-major) at which iVALID drops, iSOF is raised, or
    // RST is asserted; -1 disables each.
    task automatic runFrame(input int dropIdx, input int sofIdx, input int rstIdx);
        int  pixIdx = 0;
        int  curRun = 0;
        bit  seenF  = 1'b0;
        bit  done   = 1'b0;
        nLog = 0; nLines = 0; undTotal = 0; errTotal = 0;
        for (int i = 0; i < NPIX; i++) begin
            logData[i] = '0; logX[i] = '0; logY[i] = '0; logUnd[i] = 1'b0; logErr[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) lineLen[i] = 0;
        @(negedge CCD_PIXCLK);
        iVALID = 1'b1;
        iSOF   = 1'b1;
        @(negedge CCD_PIXCLK);
        iSOF = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (RST) begin
                checkAllZero("midrst");
                done = 1'b1;
                break;
            end
            if (oUNDERRUN)  undTotal++;
            if (oFRAME_ERR) errTotal++;
            if (oCCD_LVAL) begin
                if (nLog < NPIX) begin
                    logData[nLog] = oCCD_DATA;
                    logX[nLog]    = oX_Cont;
                    logY[nLog]    = oY_Cont;
                    logUnd[nLog]  = oUNDERRUN;
                    logErr[nLog]  = oFRAME_ERR;
                end
                nLog++;
                curRun++;
            end else if (curRun != 0) begin
                if (nLines < 4) lineLen[nLines] = curRun;
                nLines++;
                curRun = 0;
            end
            if (oCCD_FVAL) seenF = 1'b1;
            else if (seenF) begin
                done = 1'b1;
                break;
            end
            iVALID = 1'b1;
            iSOF   = 1'b0;
            if (oREADY) begin
                if (pixIdx == dropIdx) iVALID = 1'b0;
                if (pixIdx == sofIdx)  iSOF = 1'b1;
                if (pixIdx == rstIdx)  RST = 1'b1;
                pixIdx++;
            end
            @(negedge CCD_PIXCLK);
        end
        if (!done) check("frame_timeout", 0, 1);
    endtask

    initial begin
        int fvHigh;
        int rdyHigh;
        int gap;

        // Reset state
        repeat (3) @(negedge CCD_PIXCLK);
        checkAllZero("reset");
        RST = 1'b0;

        // Valid pixels without SOF must not open a frame
        iVALID = 1'b1;
        fvHigh = 0;
        rdyHigh = 0;
        repeat (6) begin
            @(negedge CCD_PIXCLK);
            if (oCCD_FVAL) fvHigh++;
            if (oREADY) rdyHigh++;
        end
        check("idle_no_sof_fval", fvHigh, 0);
        check("idle_no_sof_ready", rdyHigh, 0);

        // Clean frame
        runFrame(-1, -1, -1);
        check("f1_nlog", nLog, NPIX);
        for (int i = 0; i < NPIX; i++) begin
            check($sformatf("f1_data%0d", i), logData[i], expData[i]);
            check($sformatf("f1_x%0d", i), logX[i], i % H);
            check($sformatf("f1_y%0d", i), logY[i], i / H);
        end
        check("f1_lines", nLines, V);
        check("f1_len0", lineLen[0], H);
        check("f1_len1", lineLen[1], H);
        check("f1_und", undTotal, 0);
        check("f1_ferr", errTotal, 0);

        // FVAL-low gap with SOF waiting: VB*(H+HB) tail cycles plus the
        // one IDLE cycle in which the SOF is sampled.
        iSOF = 1'b1;
        gap = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CCD_PIXCLK);
            if (oCCD_FVAL) break;
            gap++;
        end
        check("fval_gap", gap, VB * (H + HB) + 1);
        pulseReset("rst1");

        // One-cycle underrun at row0 X=2
        runFrame(2, -1, -1);
        check("f2_nlog", nLog, NPIX);
        check("f2_data2", logData[2], 0);
        check("f2_und2", logUnd[2], 1);
        check("f2_und_total", undTotal, 1);
        check("f2_len0", lineLen[0], H);
        check("f2_data3", logData[3], 10'h040);
        check("f2_x3", logX[3], 3);
        pulseReset("rst2");

        // Misplaced SOF on pixel (1,0)
        runFrame(-1, 1, -1);
        check("f3_nlog", nLog, NPIX);
        check("f3_ferr1", logErr[1], 1);
        check("f3_ferr_total", errTotal, 1);
        check("f3_data1", logData[1], 10'h040);
        check("f3_x2", logX[2], 2);
        check("f3_y2", logY[2], 0);
        check("f3_x4", logX[4], 0);
        check("f3_y4", logY[4], 1);
        pulseReset("rst3");

        // Reset during row1 (pixel X=1,Y=1), then no SOF
        runFrame(-1, -1, H + 1);
        RST = 1'b0;
        iVALID = 1'b1;
        iSOF = 1'b0;
        fvHigh = 0;
        rdyHigh = 0;
        repeat (20) begin
            @(negedge CCD_PIXCLK);
            if (oCCD_FVAL) fvHigh++;
            if (oREADY) rdyHigh++;
        end
        check("post_rst_fval", fvHigh, 0);
        check("post_rst_ready", rdyHigh, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb2raw_bayer.md
RGB2RAW_BAYER -- requirements
Module: rgb2raw_bayer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 16: LVAL-low cycles after each line and before the first line.
REQ-004 SHALL have parameter V_BLANK, default 4: FVAL-low line periods after each frame.
REQ-005 SHALL have port CCD_PIXCLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports iRed, iGreen and iBlue, each input, 8 bits: RGB pixel.
REQ-008 SHALL have port iVALID, input, 1 bit: pixel present.
REQ-009 SHALL have port iSOF, input, 1 bit: qualifies the first pixel of a frame.
REQ-010 SHALL have port oREADY, output, 1 bit: pixel accepted when iVALID && oREADY.
REQ-011 SHALL have port oCCD_DATA, output, 10 bits: Bayer raw sample.
REQ-012 SHALL have ports oCCD_LVAL and oCCD_FVAL, each output, 1 bit: line and frame valid.
REQ-013 SHALL have ports oX_Cont and oY_Cont, each output, 11 bits: column and row of the current oCCD_DATA sample.
REQ-014 SHALL have port oUNDERRUN, output, 1 bit: one-cycle pulse per active cycle with no pixel accepted.
REQ-015 SHALL have port oFRAME_ERR, output, 1 bit: one-cycle pulse when iSOF is accepted at a position other than (0,0).

Function
REQ-016 SHALL implement the FSM states IDLE, V_FRONT, ACTIVE, H_GAP and V_TAIL.
REQ-017 IDLE: FVAL=0, LVAL=0, oREADY=0; SHALL go to V_FRONT when iVALID && iSOF are sampled high (the pixel is not consumed).
REQ-018 V_FRONT: FVAL=1, LVAL=0; SHALL last H_BLANK cycles, then go to ACTIVE with Y=0.
REQ-019 ACTIVE: oREADY=1; SHALL last exactly H_ACTIVE cycles regardless of iVALID, with X counting 0..H_ACTIVE-1.
REQ-020 H_GAP: FVAL=1, LVAL=0, oREADY=0; SHALL last H_BLANK cycles.
REQ-021 H_GAP exit: SHALL go to ACTIVE with Y+1 if Y<V_ACTIVE-1, else to V_TAIL.
REQ-022 V_TAIL: FVAL=0, LVAL=0; SHALL last V_BLANK*(H_ACTIVE+H_BLANK) cycles, then go to IDLE.
REQ-023 Bayer pattern SHALL be GRBG: even row outputs G at even X and R at odd X; odd row outputs B at even X and G at odd X.
REQ-024 8-to-10-bit expansion SHALL be {c[7:0], c[7:6]}, so 0x00 maps to 0x000 and 0xFF maps to 0x3FF.
REQ-025 oCCD_DATA, oCCD_LVAL, oCCD_FVAL, oX_Cont and oY_Cont SHALL be registered, with one cycle of latency from the acceptance edge; they SHALL stay mutually aligned.
REQ-026 An ACTIVE cycle without acceptance SHALL output 0x000 with LVAL=1 and pulse oUNDERRUN; the line length SHALL remain unchanged.
REQ-027 When LVAL=0, oCCD_DATA SHALL be 0x000.
REQ-028 A misplaced iSOF SHALL be consumed as a normal pixel; the block SHALL pulse oFRAME_ERR and SHALL NOT resynchronise counters.
REQ-029 iSOF on a pixel accepted at (0,0) SHALL be legal; a missing iSOF there SHALL NOT be flagged.
REQ-030 Blank-period counter SHALL be 16 bits and X/Y counters 11 bits; parameters SHALL satisfy H_ACTIVE, V_ACTIVE <= 2047 and V_BLANK*(H_ACTIVE+H_BLANK) < 65536.

Reset
REQ-031 RST high SHALL force IDLE, clear all counters and drive every output to 0 (oREADY, oCCD_DATA, LVAL, FVAL, oX_Cont, oY_Cont, oUNDERRUN, oFRAME_ERR) on the next edge.
REQ-032 Reset asserted mid-frame SHALL abort the frame: FVAL falls on the next edge, with no V_TAIL.
REQ-033 After reset, the block SHALL start a new frame only on a fresh iVALID && iSOF in IDLE.

Structure
REQ-034 State encoding, GRBG phase constants and the 10-bit expansion function SHALL live in a shared package, bayer_pkg.
REQ-035 A sub-module, bayer_timing_gen, SHALL contain the FSM and counters; the top SHALL hold only pixel selection and output registers.

Verification
REQ-036 Reset then a 4x2 frame (H_BLANK=2, V_BLANK=1) with continuous valid R=0x10, G=0x20, B=0xFF -> row0 data 0x080, 0x040, 0x080, 0x040; row1 data 0x3FF, 0x080, 0x3FF, 0x080; LVAL high for 4 cycles per line; FVAL low for 6 cycles after the frame.
REQ-037 iVALID dropped for one cycle at X=2 of row0 -> oCCD_DATA=0x000 at X=2, a single oUNDERRUN pulse, and LVAL still high for 4 cycles.
REQ-038 iSOF asserted on pixel (1,0) -> one oFRAME_ERR pulse with the counters unchanged.
REQ-039 RST asserted during row1 of an active line -> all outputs 0 next cycle; with iSOF held low afterwards, FVAL stays 0.
REQ-040 Default parameters with a full 640x480 frame -> 480 LVAL pulses of 640 cycles each; oY_Cont ends at 479; the return to IDLE occurs after 4*656 cycles of V_TAIL.
